// File: rtl/decoder_stage_controller_pkg.sv
// Shared stage codes and helpers for the controller and the PE array.
package decoder_stage_controller_pkg;

   localparam int STAGE_WIDTH = 3;

   localparam logic [STAGE_WIDTH-1:0] STAGE_IDLE                = 3'd0;
   localparam logic [STAGE_WIDTH-1:0] STAGE_MEASUREMENT_LOADING = 3'd1;
   localparam logic [STAGE_WIDTH-1:0] STAGE_GROW                = 3'd2;
   localparam logic [STAGE_WIDTH-1:0] STAGE_MERGE               = 3'd3;
   localparam logic [STAGE_WIDTH-1:0] STAGE_PEELING             = 3'd4;
   localparam logic [STAGE_WIDTH-1:0] STAGE_RESULT_VALID        = 3'd5;
   localparam logic [STAGE_WIDTH-1:0] STAGE_ERASURE_LOADING     = 3'd6;

   typedef struct packed {
      logic [STAGE_WIDTH-1:0] stage;
      logic                   start_ready;
      logic                   result_valid;
   } ctrl_out_t;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/decoder_stage_controller_dwell.sv
// Loadable down-counter; done is high once the loaded count has drained.
module stage_dwell_counter #(
   parameter int WIDTH = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic             done
);

   logic [WIDTH-1:0] count;

   always_ff @(posedge clk) begin
      if (!reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign done = (count == '0);

endmodule

// File: rtl/decoder_stage_controller.sv
// Global stage sequencer: load, grow/merge iterations, peel, result handoff.
module decoder_stage_controller
   import decoder_stage_controller_pkg::*;
#(
   parameter int PU_COUNT      = 64,
   parameter int ITER_WIDTH    = 8,
   parameter int MAX_ITER      = 200,
   parameter int SETTLE_CYCLES = 3,
   parameter int GROW_CYCLES   = 2,
   parameter int LOAD_CYCLES   = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start_valid,
   output logic                   start_ready,
   input  logic                   erasure_en,
   input  logic [PU_COUNT-1:0]    busy,
   input  logic [PU_COUNT-1:0]    odd,
   output logic [STAGE_WIDTH-1:0] global_stage,
   output logic                   result_valid,
   input  logic                   result_ack,
   output logic [ITER_WIDTH-1:0]  iter_count,
   output logic                   timeout
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_ERASE,
      S_GROW,
      S_MERGE,
      S_PEEL,
      S_RESULT
   } state_e;

   localparam int DWELL_MAX =
      max3(SETTLE_CYCLES, GROW_CYCLES, LOAD_CYCLES);
   localparam int DW = $clog2(DWELL_MAX + 1);

   localparam logic [DW-1:0] LOAD_LV   = DW'(LOAD_CYCLES - 1);
   localparam logic [DW-1:0] GROW_LV   = DW'(GROW_CYCLES - 1);
   localparam logic [DW-1:0] SETTLE_LV = DW'(SETTLE_CYCLES - 1);

   localparam logic [ITER_WIDTH-1:0] ITER_MAX = ITER_WIDTH'(MAX_ITER);

   state_e                state, state_nx;
   logic                  erase_q, erase_nx;
   logic [ITER_WIDTH-1:0] iter_q, iter_nx;
   logic                  timeout_q, timeout_nx;
   ctrl_out_t             out_q, out_nx;

   logic                  dwell_load;
   logic [DW-1:0]         dwell_val;
   logic                  dwell_done;
   logic                  any_busy;
   logic                  any_odd;

   assign any_busy = |busy;
   assign any_odd  = |odd;

   function automatic logic [STAGE_WIDTH-1:0] stage_of(input state_e s);
      logic [STAGE_WIDTH-1:0] code;
      code = STAGE_IDLE;
      unique case (s)
         S_LOAD:   code = STAGE_MEASUREMENT_LOADING;
         S_ERASE:  code = STAGE_ERASURE_LOADING;
         S_GROW:   code = STAGE_GROW;
         S_MERGE:  code = STAGE_MERGE;
         S_PEEL:   code = STAGE_PEELING;
         S_RESULT: code = STAGE_RESULT_VALID;
         default:  code = STAGE_IDLE;
      endcase
      return code;
   endfunction

   stage_dwell_counter #(
      .WIDTH(DW)
   ) u_dwell (
      .clk       (clk),
      .reset     (reset),
      .load      (dwell_load),
      .load_value(dwell_val),
      .done      (dwell_done)
   );

   always_comb begin
      state_nx   = state;
      erase_nx   = erase_q;
      iter_nx    = iter_q;
      timeout_nx = timeout_q;
      unique case (state)
         S_IDLE: begin
            if (start_valid && out_q.start_ready) begin
               state_nx   = S_LOAD;
               erase_nx   = erasure_en;
               iter_nx    = '0;
               timeout_nx = 1'b0;
            end
         end
         S_LOAD: begin
            if (dwell_done) begin
               state_nx = erase_q ? S_ERASE : S_GROW;
            end
         end
         S_ERASE: begin
            if (dwell_done) begin
               state_nx = S_MERGE;
            end
         end
         S_GROW: begin
            if (dwell_done) begin
               state_nx = S_MERGE;
            end
         end
         S_MERGE: begin
            if (dwell_done && !any_busy) begin
               if (!any_odd) begin
                  state_nx = S_PEEL;
               end else if (iter_q < ITER_MAX) begin
                  state_nx = S_GROW;
               end else begin
                  state_nx   = S_PEEL;
                  timeout_nx = 1'b1;
               end
            end
         end
         S_PEEL: begin
            if (dwell_done && !any_busy) begin
               state_nx = S_RESULT;
            end
         end
         S_RESULT: begin
            if (result_ack) begin
               state_nx = S_IDLE;
            end
         end
         default: state_nx = S_IDLE;
      endcase

      // One count per GROW visit, taken on entry, saturating at the cap.
      if (state_nx == S_GROW && state != S_GROW
          && iter_nx < ITER_MAX) begin
         iter_nx = iter_nx + 1'b1;
      end
   end

   always_comb begin
      dwell_load = (state_nx != state);
      dwell_val  = '0;
      unique case (state_nx)
         S_LOAD,
         S_ERASE:  dwell_val = LOAD_LV;
         S_GROW:   dwell_val = GROW_LV;
         S_MERGE,
         S_PEEL:   dwell_val = SETTLE_LV;
         default:  dwell_val = '0;
      endcase
   end

   always_comb begin
      out_nx              = '0;
      out_nx.stage        = stage_of(state_nx);
      out_nx.start_ready  = (state_nx == S_IDLE);
      out_nx.result_valid = (state_nx == S_RESULT);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= S_IDLE;
         erase_q   <= 1'b0;
         iter_q    <= '0;
         timeout_q <= 1'b0;
         out_q     <= '{stage: STAGE_IDLE,
                        start_ready: 1'b1,
                        result_valid: 1'b0};
      end else begin
         state     <= state_nx;
         erase_q   <= erase_nx;
         iter_q    <= iter_nx;
         timeout_q <= timeout_nx;
         out_q     <= out_nx;
      end
   end

   assign global_stage = out_q.stage;
   assign start_ready  = out_q.start_ready;
   assign result_valid = out_q.result_valid;
   assign iter_count   = iter_q;
   assign timeout      = timeout_q;

endmodule

// File: doc/decoder_stage_controller.md
Name: decoder_stage_controller

Overview:
- Global sequencer for the single-FPGA decoding array. It drives the global_stage bus into every processing_unit and consumes each unit's busy and odd outputs.
- Steps each syndrome round through measurement loading, then alternating grow/merge iterations until no odd cluster remains, then peeling and result handoff.
- Sits between the round-input interface (upstream) and the PE array (downstream). The correction collector reads neighbor_is_error while the stage is RESULT_VALID.

Parameters:
- PU_COUNT, 64, number of processing units whose busy/odd are monitored
- ITER_WIDTH, 8, width of the grow-iteration counter
- MAX_ITER, 200, grow iterations allowed before timeout
- SETTLE_CYCLES, 3, minimum MERGE/PEELING dwell before busy is trusted; covers the PE stage register plus the busy register
- GROW_CYCLES, 2, cycles global_stage is held at GROW
- LOAD_CYCLES, 2, cycles global_stage is held at MEASUREMENT_LOADING or ERASURE_LOADING

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low; asserted when 0, sampled on rising clk
- start_valid  in  1  new round requested; measurements are stable on the PE measurement inputs
- start_ready  out  1  controller can accept a round (high only in IDLE)
- erasure_en  in  1  sampled with start; inserts ERASURE_LOADING after MEASUREMENT_LOADING
- busy  in  PU_COUNT  per-PU busy
- odd  in  PU_COUNT  per-PU odd
- global_stage  out  STAGE_WIDTH  stage broadcast to all PUs
- result_valid  out  1  decode finished; error pattern valid
- result_ack  in  1  consumer has taken the result
- iter_count  out  ITER_WIDTH  grow iterations used this round
- timeout  out  1  MAX_ITER reached this round; valid with result_valid

Behaviour:
- Reset (reset==0): global_stage=STAGE_IDLE, start_ready=1, result_valid=0, iter_count=0, timeout=0, all counters 0. A reset during any stage returns to IDLE on the next edge; a partial round is discarded.
- All outputs are registered. global_stage changes only on a clk edge.
- IDLE:
  - start_ready=1.
  - start_valid&start_ready -> LOAD; latch erasure_en; clear iter_count and timeout.
- LOAD: global_stage=STAGE_MEASUREMENT_LOADING for LOAD_CYCLES. Then go to ERASE if erasure_en was latched, else GROW.
- ERASE: global_stage=STAGE_ERASURE_LOADING for LOAD_CYCLES -> MERGE. Erasure rounds merge before the first grow.
- GROW:
  - global_stage=STAGE_GROW for GROW_CYCLES, then -> MERGE.
  - iter_count increments once on GROW entry.
  - global_stage must leave GROW between iterations; PEs increment only on the first GROW cycle after a non-GROW cycle.
- MERGE:
  - global_stage=STAGE_MERGE. Dwell counter is cleared on entry.
  - busy and odd are ignored while dwell < SETTLE_CYCLES.
  - After the dwell, on the first cycle with ~|busy:
    - if |odd and iter_count<MAX_ITER -> GROW
    - if |odd and iter_count==MAX_ITER -> set timeout=1 and go to PEEL
    - if ~|odd -> PEEL
  - While |busy after the dwell, stay in MERGE. There is no MERGE timeout.
- PEEL:
  - global_stage=STAGE_PEELING. Dwell counter is cleared on entry.
  - After SETTLE_CYCLES, the first cycle with ~|busy -> RESULT.
  - odd is ignored in this state.
- RESULT:
  - global_stage=STAGE_RESULT_VALID and result_valid=1. Hold until result_ack.
  - On result_ack -> IDLE, with result_valid=0 on the next cycle.
  - iter_count and timeout stay held until the next accepted start.
- result_ack outside RESULT is ignored. start_valid outside IDLE is ignored; it is not queued.
- iter_count saturates at MAX_ITER and never wraps. MAX_ITER must be < 2^ITER_WIDTH.
- busy/odd reduction is one combinational OR over PU_COUNT bits. Pipeline it into one extra register if timing requires; that register is accounted for in SETTLE_CYCLES.

Decomposition:
- The shared parameters package owns:
  - STAGE_WIDTH
  - STAGE_IDLE=0, STAGE_MEASUREMENT_LOADING=1, STAGE_GROW=2, STAGE_MERGE=3, STAGE_PEELING=4, STAGE_RESULT_VALID=5, STAGE_ERASURE_LOADING=6
- The PEs already consume this package, so codes cannot drift between controller and array.
- Controller-internal state enum (IDLE, LOAD, ERASE, GROW, MERGE, PEEL, RESULT) is local to this module.
- One sub-module is natural: stage_dwell_counter, a loadable down-counter with a done flag, reused for LOAD/GROW/SETTLE timing.

Test Plan:
- Reset mid-MERGE (reset=0 for 1 cycle) -> next cycle: global_stage=0, start_ready=1, result_valid=0, iter_count=0.
- Empty syndrome: start_valid=1, erasure_en=0, busy=0, odd=0:
  - stage sequence 1,1,2,2,3,3,3,4,4,4,5
  - result_valid=1, iter_count=1, timeout=0
  - result_ack -> IDLE.
- Two-iteration round: odd=1 through first MERGE, odd=0 afterwards, busy pulsing high 4 cycles inside each MERGE -> exactly two GROW visits, iter_count=2, MERGE exits only after busy falls.
- Timeout with MAX_ITER=3 and odd held 1, busy=0 -> three GROW visits, then PEEL, RESULT with timeout=1, iter_count=3.
- Erasure round with erasure_en=1 -> stage 1,1,6,6,3 before the first 2.
- Handshake: start_valid held high during RESULT and result_ack withheld 10 cycles -> result_valid stays 1 and no new round starts. After ack, IDLE accepts the still-asserted start on the following cycle.
